// File: rtl/imsic_csr_pkg.sv
// Shared encodings for the IMSIC indirect-CSR sequencer: op codes, FSM states,
// interrupt-file CSR offsets and the latched request header.
package imsic_csr_pkg;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD      = 3'd1;
  localparam state_t ST_RD_WAIT = 3'd2;
  localparam state_t ST_WR      = 3'd3;
  localparam state_t ST_WR_WAIT = 3'd4;
  localparam state_t ST_RESP    = 3'd5;

  localparam logic [11:0] EIDELIVERY_OFF  = 12'h070;
  localparam logic [11:0] EITHRESHOLD_OFF = 12'h072;
  localparam logic [11:0] EIP0_OFF        = 12'h080;
  localparam logic [11:0] EIE0_OFF        = 12'h0C0;

  typedef struct packed {
    logic [1:0]  op;
    logic [11:0] addr;
  } csr_req_hdr_t;

endpackage

// File: rtl/imsic_csr_seq_if.sv
// Hart-side CSR request/response channel of the IMSIC CSR sequencer.
interface imsic_csr_seq_if #(
  parameter int XLEN            = 64,
  parameter int INTP_FILE_WIDTH = 3
);
  logic                       req_valid;
  logic                       req_ready;
  logic [1:0]                 req_op;
  logic [11:0]                req_addr;
  logic [INTP_FILE_WIDTH-1:0] req_file;
  logic [XLEN-1:0]            req_wdata;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [XLEN-1:0]            rsp_rdata;
  logic                       rsp_illegal;

  modport master (
    output req_valid, req_op, req_addr, req_file, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_file, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );
endinterface

// File: rtl/imsic_csr_seq.sv
// Sequences one indirect CSR access at a time into the IMSIC register file;
// set/clear run as read-then-write with the merge done between the two strobes.
module imsic_csr_seq
  import imsic_csr_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int INTP_FILE_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  imsic_csr_seq_if.slave             csr,
  output logic [11:0]                rf_csr_addr,
  output logic [INTP_FILE_WIDTH-1:0] rf_intp_file_sel,
  output logic                       rf_csr_rd,
  output logic                       rf_wdata_vld,
  output logic [XLEN-1:0]            rf_wdata,
  input  logic                       rf_rdata_vld,
  input  logic [XLEN-1:0]            rf_rdata,
  input  logic                       rf_illegal
);

  state_t          state, state_nx;
  csr_req_hdr_t    hdr_q;
  logic [XLEN-1:0] mask_q;
  logic            accept;
  logic            rd_ill;
  logic [XLEN-1:0] merged;

  assign accept      = csr.req_valid & csr.req_ready;
  // A missing read-data valid is a protocol error and is folded into illegal.
  assign rd_ill      = rf_illegal | ~rf_rdata_vld;
  assign merged      = (hdr_q.op == OP_SET) ? (rf_rdata | mask_q) : (rf_rdata & ~mask_q);
  assign rf_csr_addr = hdr_q.addr;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (accept) state_nx = (csr.req_op == OP_WR) ? ST_WR : ST_RD;
      ST_RD:      state_nx = ST_RD_WAIT;
      ST_RD_WAIT: state_nx = (hdr_q.op == OP_RD || rd_ill) ? ST_RESP : ST_WR;
      ST_WR:      state_nx = ST_WR_WAIT;
      ST_WR_WAIT: state_nx = ST_RESP;
      ST_RESP:    if (csr.rsp_ready) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Strobes and handshake flags are decoded from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= ST_IDLE;
      hdr_q            <= '0;
      mask_q           <= '0;
      rf_intp_file_sel <= '0;
      rf_wdata         <= '0;
      rf_csr_rd        <= 1'b0;
      rf_wdata_vld     <= 1'b0;
      csr.req_ready    <= 1'b1;
      csr.rsp_valid    <= 1'b0;
      csr.rsp_rdata    <= '0;
      csr.rsp_illegal  <= 1'b0;
    end else begin
      state         <= state_nx;
      csr.req_ready <= (state_nx == ST_IDLE);
      rf_csr_rd     <= (state_nx == ST_RD);
      rf_wdata_vld  <= (state_nx == ST_WR);
      csr.rsp_valid <= (state_nx == ST_RESP);
      if (state == ST_IDLE && accept) begin
        hdr_q            <= '{op: csr.req_op, addr: csr.req_addr};
        mask_q           <= csr.req_wdata;
        rf_intp_file_sel <= csr.req_file;
        rf_wdata         <= csr.req_wdata;
        csr.rsp_rdata    <= '0;
        csr.rsp_illegal  <= 1'b0;
      end
      if (state == ST_RD_WAIT) begin
        csr.rsp_illegal <= rd_ill;
        csr.rsp_rdata   <= rd_ill ? '0 : rf_rdata;
        rf_wdata        <= merged;
      end
      // Old value stays in rsp_rdata even if the write half is rejected.
      if (state == ST_WR_WAIT) csr.rsp_illegal <= rf_illegal;
    end
  end

endmodule
